// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: load-use stalls, branch flushes, multi-cycle EX freeze, operand forwarding.
// Optional stall/flush statistics counters are enabled with the HAZ_STATS_EN macro.
module pipeline_hazard_ctrl #(
    parameter int MC_CYCLES = 4,
    parameter int CNT_W     = 3
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_mc,
    input  logic       ex_wreg,
    input  logic       ex_m2reg,
    input  logic [4:0] ex_wn,
    input  logic       mem_wreg,
    input  logic       mem_m2reg,
    input  logic [4:0] mem_wn,
    input  logic       ex_branch_taken,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       ifid_flush,
    output logic       idex_en,
    output logic       idex_bubble,
    output logic [1:0] fwda,
    output logic [1:0] fwdb,
`ifdef HAZ_STATS_EN
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count,
`endif
    output logic       busy
);

    typedef enum logic {RUN, MC_BUSY} state_t;

    // The mc op is already in EX during the first busy cycle, hence the -2.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MC_CYCLES - 2);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lu;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       e_wreg,
        input logic       e_m2reg,
        input logic [4:0] e_wn,
        input logic       m_wreg,
        input logic       m_m2reg,
        input logic [4:0] m_wn
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (e_wreg && !e_m2reg && (e_wn != 5'd0) && (e_wn == src)) begin
            sel = 2'b01;
        end else if (m_wreg && (m_wn != 5'd0) && (m_wn == src)) begin
            sel = m_m2reg ? 2'b11 : 2'b10;
        end
        return sel;
    endfunction

    assign lu = ex_wreg && ex_m2reg && (ex_wn != 5'd0) &&
                ((id_use_rs && (id_rs == ex_wn)) || (id_use_rt && (id_rt == ex_wn)));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_bubble = 1'b0;
        busy        = 1'b0;
        fwda        = fwd_sel(id_rs, ex_wreg, ex_m2reg, ex_wn, mem_wreg, mem_m2reg, mem_wn);
        fwdb        = fwd_sel(id_rt, ex_wreg, ex_m2reg, ex_wn, mem_wreg, mem_m2reg, mem_wn);
        if (clrn) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            fwda        = 2'b00;
            fwdb        = 2'b00;
        end else begin
            case (state_q)
                RUN: begin
                    if (ex_branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (lu) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_bubble = 1'b1;
                    end else if (id_mc) begin
                        state_d = MC_BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
                MC_BUSY: begin
                    pc_en   = 1'b0;
                    ifid_en = 1'b0;
                    idex_en = 1'b0;
                    busy    = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clrn) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZ_STATS_EN
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] flush_count_q, flush_count_d;

    // Both counters saturate rather than wrap.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (!pc_en && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
        if ((state_q == RUN) && ex_branch_taken && (flush_count_q != 16'hFFFF)) begin
            flush_count_d = flush_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (clrn) begin
            stall_cycles_q <= 16'd0;
            flush_count_q  <= 16'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed test-plan scenarios plus randomized traffic
// compared against a cycle-level reference model (HAZ_STATS_EN adds statistics checks).
module tb_pipeline_hazard_ctrl;

    localparam int MC_CYCLES = 4;
    localparam int CNT_W     = 3;

    typedef struct packed {
        logic       clrn;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_use_rs;
        logic       id_use_rt;
        logic       id_mc;
        logic       ex_wreg;
        logic       ex_m2reg;
        logic [4:0] ex_wn;
        logic       mem_wreg;
        logic       mem_m2reg;
        logic [4:0] mem_wn;
        logic       ex_branch_taken;
    } stim_t;

    logic       clk = 1'b0;
    logic       clrn;
    logic [4:0] id_rs, id_rt, ex_wn, mem_wn;
    logic       id_use_rs, id_use_rt, id_mc;
    logic       ex_wreg, ex_m2reg, mem_wreg, mem_m2reg, ex_branch_taken;
    logic       pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, busy;
    logic [1:0] fwda, fwdb;
`ifdef HAZ_STATS_EN
    logic [15:0] stall_cycles, flush_count;
    int          ref_stall = 0;
    int          ref_flush = 0;
`endif

    int    checks = 0;
    int    passes = 0;
    int    mc_left = 0;
    stim_t s;

    pipeline_hazard_ctrl #(.MC_CYCLES(MC_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .clrn(clrn),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_mc(id_mc),
        .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wn(ex_wn),
        .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_wn(mem_wn),
        .ex_branch_taken(ex_branch_taken),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_bubble(idex_bubble),
        .fwda(fwda), .fwdb(fwdb),
`ifdef HAZ_STATS_EN
        .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input stim_t st);
        clrn            = st.clrn;
        id_rs           = st.id_rs;
        id_rt           = st.id_rt;
        id_use_rs       = st.id_use_rs;
        id_use_rt       = st.id_use_rt;
        id_mc           = st.id_mc;
        ex_wreg         = st.ex_wreg;
        ex_m2reg        = st.ex_m2reg;
        ex_wn           = st.ex_wn;
        mem_wreg        = st.mem_wreg;
        mem_m2reg       = st.mem_m2reg;
        mem_wn          = st.mem_wn;
        ex_branch_taken = st.ex_branch_taken;
        #2;
    endtask

    function automatic int refFwd(input logic [4:0] src);
        if (src == 0) return 0;
        if (ex_wreg && !ex_m2reg && ex_wn == src) return 1;
        if (mem_wreg && mem_wn == src) return mem_m2reg ? 3 : 2;
        return 0;
    endfunction

    // One clock: compare the model against the DUT mid-cycle, then advance the model at the edge.
    task automatic stepCycle();
        bit hazard, frozen;
        int e_pc, e_ifid, e_flush, e_idex, e_bub, e_busy, e_fa, e_fb;
        hazard = ex_wreg && ex_m2reg && ex_wn != 0 &&
                 ((id_use_rs && id_rs == ex_wn) || (id_use_rt && id_rt == ex_wn));
        frozen = (mc_left > 0);
        e_fa = refFwd(id_rs);
        e_fb = refFwd(id_rt);
        e_pc = 1; e_ifid = 1; e_flush = 0; e_idex = 1; e_bub = 0; e_busy = 0;
        if (clrn) begin
            e_pc = 0; e_ifid = 0; e_flush = 1; e_bub = 1; e_fa = 0; e_fb = 0;
        end else if (frozen) begin
            e_pc = 0; e_ifid = 0; e_idex = 0; e_busy = 1;
        end else if (ex_branch_taken) begin
            e_flush = 1; e_bub = 1;
        end else if (hazard) begin
            e_pc = 0; e_ifid = 0; e_bub = 1;
        end
        @(negedge clk);
        checkOutput("pc_en", 32'(pc_en), 32'(e_pc));
        checkOutput("ifid_en", 32'(ifid_en), 32'(e_ifid));
        checkOutput("ifid_flush", 32'(ifid_flush), 32'(e_flush));
        checkOutput("idex_en", 32'(idex_en), 32'(e_idex));
        checkOutput("idex_bubble", 32'(idex_bubble), 32'(e_bub));
        checkOutput("busy", 32'(busy), 32'(e_busy));
        checkOutput("fwda", 32'(fwda), 32'(e_fa));
        checkOutput("fwdb", 32'(fwdb), 32'(e_fb));
`ifdef HAZ_STATS_EN
        if (!clrn) begin
            checkOutput("stall_cycles", 32'(stall_cycles), 32'(ref_stall));
            checkOutput("flush_count", 32'(flush_count), 32'(ref_flush));
        end
`endif
        @(posedge clk);
        if (clrn) begin
            mc_left = 0;
`ifdef HAZ_STATS_EN
            ref_stall = 0;
            ref_flush = 0;
`endif
        end else begin
`ifdef HAZ_STATS_EN
            if (e_pc == 0 && ref_stall < 65535) ref_stall++;
            if (!frozen && ex_branch_taken && ref_flush < 65535) ref_flush++;
`endif
            if (frozen) mc_left--;
            else if (!ex_branch_taken && !hazard && id_mc) mc_left = MC_CYCLES - 1;
        end
        #1;
    endtask

    initial begin
        // Reset held for two cycles.
        s = '0;
        s.clrn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(s);
            checkOutput("rst_pc_en", 32'(pc_en), 32'd0);
            checkOutput("rst_idex_bubble", 32'(idex_bubble), 32'd1);
            checkOutput("rst_busy", 32'(busy), 32'd0);
            stepCycle();
        end
        s.clrn = 1'b0;
        applyStimulus(s);
        checkOutput("post_rst_pc_en", 32'(pc_en), 32'd1);
        checkOutput("post_rst_ifid_en", 32'(ifid_en), 32'd1);
        checkOutput("post_rst_idex_en", 32'(idex_en), 32'd1);
        checkOutput("post_rst_fwd", 32'({fwda, fwdb}), 32'd0);
        stepCycle();

        // Forwarding from EX ALU and MEM load, then register 0.
        s = '0;
        s.ex_wreg = 1'b1; s.ex_wn = 5'd5; s.id_rs = 5'd5;
        s.mem_wreg = 1'b1; s.mem_m2reg = 1'b1; s.mem_wn = 5'd6; s.id_rt = 5'd6;
        applyStimulus(s);
        checkOutput("fwd_ex_alu", 32'(fwda), 32'd1);
        checkOutput("fwd_mem_load", 32'(fwdb), 32'd3);
        stepCycle();
        s.ex_wn = 5'd0; s.id_rs = 5'd0;
        applyStimulus(s);
        checkOutput("fwd_r0", 32'(fwda), 32'd0);
        stepCycle();

        // Load-use: one bubble, then forwarded from MEM load data.
        s = '0;
        s.ex_wreg = 1'b1; s.ex_m2reg = 1'b1; s.ex_wn = 5'd3; s.id_use_rt = 1'b1; s.id_rt = 5'd3;
        applyStimulus(s);
        checkOutput("lu_pc_en", 32'(pc_en), 32'd0);
        checkOutput("lu_ifid_en", 32'(ifid_en), 32'd0);
        checkOutput("lu_bubble", 32'(idex_bubble), 32'd1);
        stepCycle();
        s = '0;
        s.mem_wreg = 1'b1; s.mem_m2reg = 1'b1; s.mem_wn = 5'd3; s.id_use_rt = 1'b1; s.id_rt = 5'd3;
        applyStimulus(s);
        checkOutput("lu_after_fwdb", 32'(fwdb), 32'd3);
        checkOutput("lu_after_pc_en", 32'(pc_en), 32'd1);
        stepCycle();

        // Branch wins over a concurrent load-use.
        s = '0;
        s.ex_wreg = 1'b1; s.ex_m2reg = 1'b1; s.ex_wn = 5'd3; s.id_use_rt = 1'b1; s.id_rt = 5'd3;
        s.ex_branch_taken = 1'b1;
        applyStimulus(s);
        checkOutput("br_flush", 32'(ifid_flush), 32'd1);
        checkOutput("br_bubble", 32'(idex_bubble), 32'd1);
        checkOutput("br_pc_en", 32'(pc_en), 32'd1);
        stepCycle();

        // Multi-cycle op: MC_CYCLES-1 frozen cycles, then back to RUN.
        s = '0;
        s.id_mc = 1'b1;
        applyStimulus(s);
        checkOutput("mc_issue_pc_en", 32'(pc_en), 32'd1);
        stepCycle();
        s.id_mc = 1'b0;
        for (int i = 0; i < MC_CYCLES - 1; i++) begin
            applyStimulus(s);
            checkOutput("mc_busy", 32'(busy), 32'd1);
            checkOutput("mc_frozen", 32'({pc_en, ifid_en, idex_en}), 32'd0);
            stepCycle();
        end
        applyStimulus(s);
        checkOutput("mc_done_busy", 32'(busy), 32'd0);
        checkOutput("mc_done_pc_en", 32'(pc_en), 32'd1);
        stepCycle();

        // Reset on the second busy cycle aborts the op.
        s.id_mc = 1'b1;
        applyStimulus(s);
        stepCycle();
        s.id_mc = 1'b0;
        applyStimulus(s);
        checkOutput("mc2_busy", 32'(busy), 32'd1);
        stepCycle();
        s.clrn = 1'b1;
        applyStimulus(s);
        checkOutput("mc2_rst_busy", 32'(busy), 32'd0);
        stepCycle();
        s.clrn = 1'b0;
        applyStimulus(s);
        checkOutput("mc2_after_busy", 32'(busy), 32'd0);
        checkOutput("mc2_after_pc_en", 32'(pc_en), 32'd1);
        stepCycle();

        // Randomized traffic on a small register window to provoke matches.
        for (int n = 0; n < 600; n++) begin
            s.clrn            = ($urandom_range(0, 99) < 2);
            s.id_rs           = 5'($urandom_range(0, 3));
            s.id_rt           = 5'($urandom_range(0, 3));
            s.id_use_rs       = 1'($urandom_range(0, 1));
            s.id_use_rt       = 1'($urandom_range(0, 1));
            s.id_mc           = ($urandom_range(0, 99) < 12);
            s.ex_wreg         = 1'($urandom_range(0, 1));
            s.ex_m2reg        = 1'($urandom_range(0, 1));
            s.ex_wn           = 5'($urandom_range(0, 3));
            s.mem_wreg        = 1'($urandom_range(0, 1));
            s.mem_m2reg       = 1'($urandom_range(0, 1));
            s.mem_wn          = 5'($urandom_range(0, 3));
            s.ex_branch_taken = ($urandom_range(0, 99) < 15);
            applyStimulus(s);
            stepCycle();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
